// File: rtl/serial_ripple_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e    : sequencing states (IDLE, RUN, DONE)
//   cycles_f   : clock cycles per operation (WIDTH/DIGIT)
//   cnt_w_f    : digit-index counter width, max(1, clog2(CYCLES))
//   width_ok_f : legality of a WIDTH/DIGIT pairing, used at elaboration
`timescale 1ns/1ps
package addsub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int cycles_f(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_w_f(input int width, input int digit);
        int c;
        c = width / digit;
        return (c <= 1) ? 1 : $clog2(c);
    endfunction

    function automatic bit width_ok_f(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_ripple_addsub_if.sv
// Start/done handshake and operand/result bus of the serial adder/subtractor.
//   master : requester side (drives start, sub, a, b, cin)
//   slave  : adder side (drives busy, done, sum, cout, ovf)
`timescale 1ns/1ps
interface serial_ripple_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_ripple_addsub_rca_slice.sv
// Combinational DIGIT-bit ripple-carry chain of full adders.
//   x, y     : digit operands
//   ci       : carry into bit 0
//   s        : digit sum
//   co       : carry out of the top bit
//   c_msb_in : carry into the top bit (overflow detection on the last digit)
`timescale 1ns/1ps
module rca_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/serial_ripple_addsub.sv
// Digit-serial adder/subtractor: processes a WIDTH-bit operand pair DIGIT
// bits per clock through one ripple-carry slice, carry registered between
// digits, framed by a start/busy/done handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_ripple_addsub_if
//           (start, sub, a, b, cin in; busy, done, sum, cout, ovf out)
`timescale 1ns/1ps
module serial_ripple_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_ripple_addsub_if.slave bus
);
    localparam int               CYCLES = cycles_f(WIDTH, DIGIT);
    localparam int               CNT_W  = cnt_w_f(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(CYCLES - 1);

    generate
        if (!width_ok_f(WIDTH, DIGIT)) begin : g_bad_params
            $error("serial_ripple_addsub: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   idx_q, idx_d;

    logic [DIGIT-1:0]   slice_s;
    logic               slice_co;
    logic               slice_cmsb;

    // Operands shift right each digit, so the slice always sees the low digit.
    rca_slice #(.DIGIT(DIGIT)) u_slice (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .ci       (carry_q),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert b and force carry-in.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[idx_q*DIGIT +: DIGIT] = slice_s;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_co;
                if (idx_q == LAST) begin
                    cout_d  = slice_co;
                    ovf_d   = slice_cmsb ^ slice_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_ripple_addsub.sv
// Bench for serial_ripple_addsub: three instances (DIGIT = 8, 2, 1; WIDTH = 8)
// run the same operations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_ripple_addsub;
    localparam int CYC [3] = '{1, 4, 8};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;
    logic       op_sub = 1'b0;
    logic       op_cin = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    serial_ripple_addsub_if #(.WIDTH(8)) bus0 ();
    serial_ripple_addsub_if #(.WIDTH(8)) bus1 ();
    serial_ripple_addsub_if #(.WIDTH(8)) bus2 ();

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus0.sub = op_sub;  assign bus1.sub = op_sub;  assign bus2.sub = op_sub;
    assign bus0.a   = op_a;    assign bus1.a   = op_a;    assign bus2.a   = op_a;
    assign bus0.b   = op_b;    assign bus1.b   = op_b;    assign bus2.b   = op_b;
    assign bus0.cin = op_cin;  assign bus1.cin = op_cin;  assign bus2.cin = op_cin;

    serial_ripple_addsub #(.WIDTH(8), .DIGIT(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    serial_ripple_addsub #(.WIDTH(8), .DIGIT(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_ripple_addsub #(.WIDTH(8), .DIGIT(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [2:0] busy_v, done_v, cout_v, ovf_v;
    logic [7:0] sum_v [3];
    assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
    assign done_v = {bus2.done, bus1.done, bus0.done};
    assign cout_v = {bus2.cout, bus1.cout, bus0.cout};
    assign ovf_v  = {bus2.ovf,  bus1.ovf,  bus0.ovf};
    assign sum_v[0] = bus0.sum;
    assign sum_v[1] = bus1.sum;
    assign sum_v[2] = bus2.sum;

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [9:0] model(input logic s, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
        int ua, ub, sa, sb, r, sr;
        logic co, ov;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        if (!s) begin
            r  = ua + ub + int'(ci);
            sr = sa + sb + int'(ci);
        end else begin
            r  = ua + (255 - ub) + 1;
            sr = sa - sb;
        end
        co = (r > 255);
        ov = (sr > 127) || (sr < -128);
        return {ov, co, 8'(r)};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, expv);
        end
    endtask

    // Start the operation on the instances in en; sample after every edge.
    // If rep >= 0, re-pulse start (new operands) on busy-capable instances
    // so that it lands on edge rep+1, which must be ignored.
    task automatic run_op(input logic [2:0] en, input logic s, input logic [7:0] a,
                          input logic [7:0] b, input logic ci, input int rep);
        logic [9:0] expv;
        int done_at [3];
        int busy_cnt [3];
        expv = model(s, a, b, ci);
        @(negedge clk);
        op_sub = s; op_a = a; op_b = b; op_cin = ci;
        start_v = en;
        for (int i = 0; i < 3; i++) begin
            done_at[i]  = -1;
            busy_cnt[i] = 0;
        end
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == rep) begin
                start_v = en & 3'b110;
                op_a    = 8'($urandom);
                op_b    = 8'($urandom);
                op_sub  = 1'($urandom);
                op_cin  = 1'($urandom);
            end else begin
                start_v = '0;
            end
            for (int i = 0; i < 3; i++) begin
                if (en[i]) begin
                    if (busy_v[i]) busy_cnt[i]++;
                    if (done_v[i] && done_at[i] < 0) begin
                        done_at[i] = c;
                        chk("sum",  i, sum_v[i],  expv[7:0]);
                        chk("cout", i, cout_v[i], expv[8]);
                        chk("ovf",  i, ovf_v[i],  expv[9]);
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                chk("latency",     i, done_at[i],  CYC[i]);
                chk("busy_cycles", i, busy_cnt[i], CYC[i]);
                chk("sum_hold",    i, sum_v[i],    expv[7:0]);
            end
        end
    endtask

    initial begin
        int c;
        int ndone;
        logic [9:0] e2;

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", i, busy_v[i], 1'b0);
            chk("rst_done", i, done_v[i], 1'b0);
            chk("rst_sum",  i, sum_v[i],  8'h00);
            chk("rst_cout", i, cout_v[i], 1'b0);
            chk("rst_ovf",  i, ovf_v[i],  1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases on all three digit widths
        run_op(3'b111, 1'b0, 8'h7F, 8'h01, 1'b0, -1);
        run_op(3'b111, 1'b0, 8'hFF, 8'h01, 1'b1, -1);
        run_op(3'b111, 1'b1, 8'h05, 8'h07, 1'b0, -1);
        run_op(3'b111, 1'b1, 8'h80, 8'h01, 1'b1, -1);

        // Start re-pulsed mid-run must be ignored
        run_op(3'b111, 1'b0, 8'h10, 8'h20, 1'b0, 1);

        // Back-to-back on DIGIT=2: start presented in the done cycle
        @(negedge clk);
        op_sub = 1'b0; op_a = 8'h33; op_b = 8'h44; op_cin = 1'b0;
        start_v = 3'b010;
        @(negedge clk);
        start_v = '0;
        c = 0;
        while (!done_v[1] && c < 12) begin
            @(negedge clk);
            c++;
        end
        chk("b2b_lat1", 1, c, 4);
        chk("b2b_sum1", 1, sum_v[1], 8'h77);
        op_sub = 1'b1; op_a = 8'h10; op_b = 8'h20; op_cin = 1'b0;
        start_v = 3'b010;
        @(negedge clk);
        start_v = '0;
        chk("b2b_no_gap", 1, busy_v[1], 1'b1);
        c = 0;
        while (!done_v[1] && c < 12) begin
            @(negedge clk);
            c++;
        end
        e2 = model(1'b1, 8'h10, 8'h20, 1'b0);
        chk("b2b_lat2", 1, c, 4);
        chk("b2b_sum2", 1, sum_v[1], e2[7:0]);
        chk("b2b_cout2", 1, cout_v[1], e2[8]);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-run
        op_sub = 1'b0; op_a = 8'h12; op_b = 8'h34; op_cin = 1'b1;
        start_v = 3'b111;
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_busy", i, busy_v[i], 1'b0);
            chk("mid_rst_done", i, done_v[i], 1'b0);
            chk("mid_rst_sum",  i, sum_v[i],  8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (done_v[i]) ndone++;
        end
        chk("no_done_after_rst", 0, ndone, 0);
        run_op(3'b111, 1'b0, 8'h12, 8'h34, 1'b1, -1);

        // Randomised operations
        for (int k = 0; k < 12; k++) begin
            run_op(3'b111, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
